pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters: H_ACTIVE 640, visible width px; V_ACTIVE 480, visible height px; PADDLE_H 64, paddle height; PADDLE_W 8, paddle width; BALL_SZ 8, ball edge; BALL_SPD 2, px/frame per axis; PAD_STEP 4, player px/frame; AI_STEP 3, AI px/frame; WIN_SCORE 9; SERVE_FRAMES 30; POINT_FRAMES 60.
REQ-002 Ports: clk in 1, system clock; rst_n in 1, reset, asynchronous, active-low.
REQ-003 Ports: frame_tick in 1, one-cycle pulse per frame at vsync start; joy_up/joy_down/joy_select in 1 each, raw asynchronous buttons, active-high.
REQ-004 Ports: ball_x/ball_y out 10, ball top-left; pad_l_y/pad_r_y out 10, left (player) and right (AI) paddle tops; score_l/score_r out 4; game_state out 3, current FSM state.

Function
REQ-005 Joystick inputs SHALL pass a 2-FF synchronizer; joy_select SHALL yield a one-cycle rising-edge pulse sel_p.
REQ-006 FSM states: IDLE, SERVE, PLAY, POINT, OVER; all position/score updates SHALL occur only in cycles with frame_tick=1, except as stated.
REQ-007 IDLE: ball centred (316,236); sel_p -> SERVE, frame counter cleared, scores cleared.
REQ-008 SERVE: ball held centred; after SERVE_FRAMES frame_ticks -> PLAY, dx = serve_dir, dy = down.
REQ-009 PLAY: per frame_tick, ball_x += ±BALL_SPD, ball_y += ±BALL_SPD per dx/dy.
REQ-010 Top wall: dy up and ball_y < BALL_SPD -> ball_y=0, dy=down; bottom: dy down and ball_y+BALL_SZ+BALL_SPD > V_ACTIVE -> ball_y=V_ACTIVE-BALL_SZ, dy=up.
REQ-011 Left paddle face at x=16+PADDLE_W=24: dx left, ball_x >= 24, ball_x-BALL_SPD < 24, and ball_y+BALL_SZ > pad_l_y and ball_y < pad_l_y+PADDLE_H -> ball_x=24, dx=right; right paddle mirrored with face at x=H_ACTIVE-24-BALL_SZ=608 for ball_x.
REQ-012 Miss: dx left and ball_x < BALL_SPD -> score_r+1, serve_dir=left, POINT; dx right and ball_x+BALL_SZ+BALL_SPD > H_ACTIVE -> score_l+1, serve_dir=right, POINT.
REQ-013 Paddle and wall events in the same frame SHALL both apply (corner bounce flips dx and dy).
REQ-014 POINT: ball frozen; incremented score == WIN_SCORE -> OVER on next cycle; else after POINT_FRAMES frame_ticks -> SERVE.
REQ-015 OVER: positions frozen, scores held; sel_p -> IDLE.
REQ-016 Player paddle in SERVE/PLAY: per frame_tick, up only -> -PAD_STEP, down only -> +PAD_STEP, both/none -> hold; clamp to [0, V_ACTIVE-PADDLE_H] with no wrap.
REQ-017 AI paddle in PLAY: per frame_tick, move AI_STEP toward aligning paddle centre with ball centre; deadband |diff| < AI_STEP -> hold; same clamp.
REQ-018 Scores SHALL saturate at WIN_SCORE; all arithmetic 11-bit signed internally to avoid underflow.
REQ-019 sel_p and frame_tick in the same cycle in IDLE: transition to SERVE; frame_tick not counted.

Reset
REQ-020 rst_n low SHALL asynchronously force: state IDLE, ball (316,236), pad_l_y=pad_r_y=208, scores 0, dx left, dy down, serve_dir left, counters 0, synchronizers 0.
REQ-021 Reset asserted mid-PLAY SHALL abort play with no score change; release returns to IDLE.

Structure
REQ-022 Package pong_pkg SHALL hold the REQ-001 constants, the state encoding and the derived face/centre constants.
REQ-023 Sub-module joy_sync SHALL implement the synchronizer and select edge detector; the rest stays in pong_game_ctrl.

Verification
REQ-024 Reset, then sel_p, then 30 frame_ticks -> state PLAY; after 1 tick ball_x=314, ball_y=238.
REQ-025 joy_up held 60 frames from pad_l_y=208 -> pad_l_y=0 after 52 ticks, then stays 0; up+down -> unchanged.
REQ-026 Ball at y=1 moving up -> ball_y=0, dy=down; ball at y=471 moving down -> 472, dy=up.
REQ-027 Ball at x=25 moving left, paddle overlapping -> ball_x=24, dx=right; paddle clear -> continues, reaches x<2 -> score_r=1, POINT, SERVE after 60 ticks.
REQ-028 Force score_l=8, right miss -> score_l=9, OVER; sel_p -> IDLE, then sel_p -> scores 0.
REQ-029 rst_n pulsed low mid-PLAY (asynchronous to clk) -> all outputs at REQ-020 values immediately.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry and rule constants, state encoding and small
// arithmetic helpers for the pong game controller. All pixel quantities are
// 11-bit signed so that intermediate results may go negative without wrapping.
package pong_pkg;

  // Screen, sprite and speed parameters (pixels, pixels per frame).
  localparam logic signed [10:0] H_ACTIVE = 11'sd640;
  localparam logic signed [10:0] V_ACTIVE = 11'sd480;
  localparam logic signed [10:0] PADDLE_H = 11'sd64;
  localparam logic signed [10:0] PADDLE_W = 11'sd8;
  localparam logic signed [10:0] BALL_SZ  = 11'sd8;
  localparam logic signed [10:0] BALL_SPD = 11'sd2;
  localparam logic signed [10:0] PAD_STEP = 11'sd4;
  localparam logic signed [10:0] AI_STEP  = 11'sd3;

  // Game rules.
  localparam logic [3:0] WIN_SCORE    = 4'd9;
  localparam logic [5:0] SERVE_FRAMES = 6'd30;
  localparam logic [5:0] POINT_FRAMES = 6'd60;

  // Derived positions: paddle faces, centred ball/paddle, paddle travel limit.
  localparam logic signed [10:0] L_FACE    = 11'sd16 + PADDLE_W;
  localparam logic signed [10:0] R_FACE    = H_ACTIVE - 11'sd24 - BALL_SZ;
  localparam logic signed [10:0] BALL_X0   = (H_ACTIVE - BALL_SZ) / 11'sd2;
  localparam logic signed [10:0] BALL_Y0   = (V_ACTIVE - BALL_SZ) / 11'sd2;
  localparam logic signed [10:0] PAD_Y0    = (V_ACTIVE - PADDLE_H) / 11'sd2;
  localparam logic signed [10:0] PAD_MAX   = V_ACTIVE - PADDLE_H;
  localparam logic signed [10:0] BALL_HALF = BALL_SZ / 11'sd2;
  localparam logic signed [10:0] PAD_HALF  = PADDLE_H / 11'sd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  // Keep a paddle top inside [0, PAD_MAX].
  function automatic logic signed [10:0] clamp_pad(input logic signed [10:0] y);
    logic signed [10:0] r;
    if (y < 11'sd0) r = 11'sd0;
    else if (y > PAD_MAX) r = PAD_MAX;
    else r = y;
    return r;
  endfunction

  // Score increment that saturates at WIN_SCORE.
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    logic [3:0] r;
    if (s >= WIN_SCORE) r = WIN_SCORE;
    else r = s + 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/joy_sync.sv
// joy_sync: two-flop synchronizers for the raw joystick buttons plus a
// rising-edge detector on select.
// Ports: clk, rst_n (async active-low); joy_up/joy_down/joy_select raw inputs;
//        up_s/down_s synchronized levels; sel_p one-cycle select press pulse.
module joy_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic joy_up,
  input  logic joy_down,
  input  logic joy_select,
  output logic up_s,
  output logic down_s,
  output logic sel_p
);

  logic [2:0] meta_r;
  logic [2:0] sync_r;
  logic       sel_d_r;

  // Two-stage synchronizer chain and delayed select for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r  <= 3'b000;
      sync_r  <= 3'b000;
      sel_d_r <= 1'b0;
    end else begin
      meta_r  <= {joy_select, joy_down, joy_up};
      sync_r  <= meta_r;
      sel_d_r <= sync_r[2];
    end
  end

  assign up_s   = sync_r[0];
  assign down_s = sync_r[1];
  assign sel_p  = sync_r[2] & ~sel_d_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game FSM, ball physics, player/AI paddles and scoring for a
// 640x480 pong game. Positions and scores advance only on frame_tick.
// Ports: clk, rst_n (async active-low), frame_tick (per-frame pulse),
//        joy_up/joy_down/joy_select (raw buttons);
//        ball_x/ball_y ball top-left, pad_l_y/pad_r_y paddle tops,
//        score_l/score_r scores, game_state current FSM state.
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       joy_up,
  input  logic       joy_down,
  input  logic       joy_select,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] game_state
);

  logic up_s, down_s, sel_p_s;

  joy_sync u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .joy_up     (joy_up),
    .joy_down   (joy_down),
    .joy_select (joy_select),
    .up_s       (up_s),
    .down_s     (down_s),
    .sel_p      (sel_p_s)
  );

  game_state_t state_r, state_n;
  logic signed [10:0] bx_r, by_r, pl_r, pr_r;
  logic signed [10:0] bx_n, by_n, pl_n, pr_n;
  logic [3:0] sl_r, sr_r, sl_n, sr_n;
  logic [5:0] cnt_r, cnt_n;
  // Direction flags: dx 1 = right, dy 1 = down, dir 1 = serve to the right.
  logic dx_r, dy_r, dir_r, dx_n, dy_n, dir_n;

  logic signed [10:0] pl_mv_s, pr_mv_s, by_mv_s, ai_diff_s;
  logic dy_mv_s, hit_l_s, hit_r_s, miss_l_s, miss_r_s;

  // Candidate paddle positions for this frame (player joystick, AI tracking).
  always_comb begin
    pl_mv_s = pl_r;
    if (up_s && !down_s) pl_mv_s = clamp_pad(pl_r - PAD_STEP);
    else if (down_s && !up_s) pl_mv_s = clamp_pad(pl_r + PAD_STEP);
    else pl_mv_s = pl_r;
    // Positive diff: ball centre lies below paddle centre.
    ai_diff_s = (by_r + BALL_HALF) - (pr_r + PAD_HALF);
    if (ai_diff_s >= AI_STEP) pr_mv_s = clamp_pad(pr_r + AI_STEP);
    else if (ai_diff_s <= -AI_STEP) pr_mv_s = clamp_pad(pr_r - AI_STEP);
    else pr_mv_s = pr_r;
  end

  // Candidate vertical motion with wall bounce, plus paddle-hit and miss detection.
  always_comb begin
    by_mv_s = by_r;
    dy_mv_s = dy_r;
    if (!dy_r && (by_r < BALL_SPD)) begin
      by_mv_s = 11'sd0;
      dy_mv_s = 1'b1;
    end else if (dy_r && (by_r + BALL_SZ + BALL_SPD > V_ACTIVE)) begin
      by_mv_s = V_ACTIVE - BALL_SZ;
      dy_mv_s = 1'b0;
    end else if (dy_r) begin
      by_mv_s = by_r + BALL_SPD;
    end else begin
      by_mv_s = by_r - BALL_SPD;
    end
    // A hit needs the ball to cross the face this frame while overlapping the paddle.
    hit_l_s  = !dx_r && (bx_r >= L_FACE) && (bx_r - BALL_SPD < L_FACE) &&
               (by_r + BALL_SZ > pl_r) && (by_r < pl_r + PADDLE_H);
    hit_r_s  = dx_r && (bx_r <= R_FACE) && (bx_r + BALL_SPD > R_FACE) &&
               (by_r + BALL_SZ > pr_r) && (by_r < pr_r + PADDLE_H);
    miss_l_s = !dx_r && (bx_r < BALL_SPD);
    miss_r_s = dx_r && (bx_r + BALL_SZ + BALL_SPD > H_ACTIVE);
  end

  // Next-state and datapath update for the game FSM.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    bx_n    = bx_r;
    by_n    = by_r;
    pl_n    = pl_r;
    pr_n    = pr_r;
    sl_n    = sl_r;
    sr_n    = sr_r;
    dx_n    = dx_r;
    dy_n    = dy_r;
    dir_n   = dir_r;
    case (state_r)
      ST_IDLE: begin
        bx_n = BALL_X0;
        by_n = BALL_Y0;
        // A coincident frame_tick is deliberately not counted here.
        if (sel_p_s) begin
          state_n = ST_SERVE;
          cnt_n   = 6'd0;
          sl_n    = 4'd0;
          sr_n    = 4'd0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SERVE: begin
        bx_n = BALL_X0;
        by_n = BALL_Y0;
        if (frame_tick) begin
          pl_n = pl_mv_s;
          if (cnt_r == SERVE_FRAMES - 6'd1) begin
            state_n = ST_PLAY;
            cnt_n   = 6'd0;
            dx_n    = dir_r;
            dy_n    = 1'b1;
          end else begin
            cnt_n = cnt_r + 6'd1;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      ST_PLAY: begin
        if (frame_tick) begin
          pl_n = pl_mv_s;
          pr_n = pr_mv_s;
          by_n = by_mv_s;
          dy_n = dy_mv_s;
          if (hit_l_s) begin
            bx_n = L_FACE;
            dx_n = 1'b1;
          end else if (hit_r_s) begin
            bx_n = R_FACE;
            dx_n = 1'b0;
          end else if (miss_l_s) begin
            sr_n    = score_inc(sr_r);
            dir_n   = 1'b0;
            state_n = ST_POINT;
            cnt_n   = 6'd0;
          end else if (miss_r_s) begin
            sl_n    = score_inc(sl_r);
            dir_n   = 1'b1;
            state_n = ST_POINT;
            cnt_n   = 6'd0;
          end else if (dx_r) begin
            bx_n = bx_r + BALL_SPD;
          end else begin
            bx_n = bx_r - BALL_SPD;
          end
        end else begin
          state_n = ST_PLAY;
        end
      end
      ST_POINT: begin
        // A winning score ends the game on the next clock, without a frame_tick.
        if ((sl_r == WIN_SCORE) || (sr_r == WIN_SCORE)) begin
          state_n = ST_OVER;
        end else if (frame_tick) begin
          if (cnt_r == POINT_FRAMES - 6'd1) begin
            state_n = ST_SERVE;
            cnt_n   = 6'd0;
            bx_n    = BALL_X0;
            by_n    = BALL_Y0;
          end else begin
            cnt_n = cnt_r + 6'd1;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      ST_OVER: begin
        if (sel_p_s) state_n = ST_IDLE;
        else state_n = ST_OVER;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      bx_r    <= BALL_X0;
      by_r    <= BALL_Y0;
      pl_r    <= PAD_Y0;
      pr_r    <= PAD_Y0;
      sl_r    <= 4'd0;
      sr_r    <= 4'd0;
      dx_r    <= 1'b0;
      dy_r    <= 1'b1;
      dir_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      bx_r    <= bx_n;
      by_r    <= by_n;
      pl_r    <= pl_n;
      pr_r    <= pr_n;
      sl_r    <= sl_n;
      sr_r    <= sr_n;
      dx_r    <= dx_n;
      dy_r    <= dy_n;
      dir_r   <= dir_n;
    end
  end

  assign ball_x     = bx_r[9:0];
  assign ball_y     = by_r[9:0];
  assign pad_l_y    = pl_r[9:0];
  assign pad_r_y    = pr_r[9:0];
  assign score_l    = sl_r;
  assign score_r    = sr_r;
  assign game_state = state_r;

endmodule

// File: tb/tb_pong_game_ctrl.sv
`timescale 1ns/1ps
// Randomised bench for pong_game_ctrl: a frame-level game model predicts the
// outputs after every frame_tick; a monitor compares them as the DUT presents
// them.
module tb_pong_game_ctrl;
  import pong_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic joy_up = 1'b0, joy_down = 1'b0, joy_select = 1'b0;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;

  pong_game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .joy_up(joy_up), .joy_down(joy_down), .joy_select(joy_select),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state)
  );

  always #5 clk = ~clk;

  typedef struct { int bx; int by; int pl; int pr; int sl; int sr; int st; } snap_t;
  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Game model: plain integers, directions as +1/-1.
  int m_st, m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_dx, m_dy, m_dir, m_cnt;
  int m_track;  // remaining left-paddle returns the stimulus tries to make this rally

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_state"}, int'(game_state), int'(ST_IDLE));
    check({tag, "_ball_x"}, int'(ball_x), 316);
    check({tag, "_ball_y"}, int'(ball_y), 236);
    check({tag, "_pad_l"}, int'(pad_l_y), 208);
    check({tag, "_pad_r"}, int'(pad_r_y), 208);
    check({tag, "_score_l"}, int'(score_l), 0);
    check({tag, "_score_r"}, int'(score_r), 0);
  endtask

  task automatic model_reset();
    m_st = int'(ST_IDLE); m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
    m_sl = 0; m_sr = 0; m_dx = -1; m_dy = 1; m_dir = -1; m_cnt = 0; m_track = 0;
  endtask

  task automatic enter_serve();
    m_st = int'(ST_SERVE); m_cnt = 0; m_bx = 316; m_by = 236;
    m_track = $urandom_range(0, 1);
  endtask

  // A winning point becomes game over one clock later, well before the next frame.
  task automatic resolve();
    if (m_st == int'(ST_POINT) && (m_sl == 9 || m_sr == 9)) m_st = int'(ST_OVER);
  endtask

  task automatic model_select();
    resolve();
    if (m_st == int'(ST_IDLE)) begin
      m_sl = 0; m_sr = 0; enter_serve();
    end else if (m_st == int'(ST_OVER)) begin
      m_st = int'(ST_IDLE); m_bx = 316; m_by = 236;
    end
  endtask

  task automatic move_player(input bit up, input bit dn);
    if (up && !dn) m_pl = (m_pl - 4 < 0) ? 0 : m_pl - 4;
    if (dn && !up) m_pl = (m_pl + 4 > 416) ? 416 : m_pl + 4;
  endtask

  task automatic model_tick(input bit up, input bit dn);
    int nx, ny, d;
    bit ovl_l, ovl_r;
    resolve();
    if (m_st == int'(ST_SERVE)) begin
      move_player(up, dn);
      m_cnt++;
      if (m_cnt == 30) begin
        m_st = int'(ST_PLAY); m_dx = m_dir; m_dy = 1;
      end
    end else if (m_st == int'(ST_PLAY)) begin
      ovl_l = (m_by + 8 > m_pl) && (m_by < m_pl + 64);
      ovl_r = (m_by + 8 > m_pr) && (m_by < m_pr + 64);
      ny = m_by + 2 * m_dy;
      if (ny < 0) begin ny = 0; m_dy = 1; end
      else if (ny + 8 > 480) begin ny = 472; m_dy = -1; end
      nx = m_bx + 2 * m_dx;
      if (m_dx < 0 && m_bx >= 24 && nx < 24 && ovl_l) begin
        nx = 24; m_dx = 1; if (m_track > 0) m_track--;
      end else if (m_dx > 0 && m_bx <= 608 && nx > 608 && ovl_r) begin
        nx = 608; m_dx = -1;
      end else if (nx < 0) begin
        nx = m_bx; m_sr = (m_sr < 9) ? m_sr + 1 : 9; m_dir = -1;
        m_st = int'(ST_POINT); m_cnt = 0;
      end else if (nx + 8 > 640) begin
        nx = m_bx; m_sl = (m_sl < 9) ? m_sl + 1 : 9; m_dir = 1;
        m_st = int'(ST_POINT); m_cnt = 0;
      end
      d = (m_by + 4) - (m_pr + 32);
      if (d >= 3) m_pr = (m_pr + 3 > 416) ? 416 : m_pr + 3;
      else if (d <= -3) m_pr = (m_pr - 3 < 0) ? 0 : m_pr - 3;
      move_player(up, dn);
      m_bx = nx; m_by = ny;
    end else if (m_st == int'(ST_POINT)) begin
      m_cnt++;
      if (m_cnt == 60) enter_serve();
    end
  endtask

  task automatic push_expected();
    exp_q.push_back('{m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st});
  endtask

  // One frame: set buttons, let them settle through the synchronizer, pulse frame_tick.
  task automatic do_frame(input bit up, input bit dn);
    joy_up = up; joy_down = dn;
    repeat (3) @(posedge clk);
    #1 frame_tick = 1'b1;
    model_tick(up, dn);
    push_expected();
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  task automatic press_select();
    joy_select = 1'b1;
    repeat (4) @(posedge clk);
    #1 joy_select = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    model_select();
  endtask

  // Select pulse lands on the same clock as a frame_tick.
  task automatic press_select_on_tick();
    joy_select = 1'b1;
    repeat (2) @(posedge clk);
    #1 frame_tick = 1'b1;
    model_select();
    push_expected();
    @(posedge clk);
    #1 frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 joy_select = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Random buttons, or chase the ball while this rally still wants returns.
  task automatic auto_frame();
    bit up, dn;
    int r;
    if (m_track > 0 && m_st == int'(ST_PLAY)) begin
      up = (m_by + 4 < m_pl + 28);
      dn = (m_by + 4 > m_pl + 36);
    end else begin
      r = $urandom_range(0, 3);
      up = r[0]; dn = r[1];
    end
    do_frame(up, dn);
  endtask

  // Monitor: every frame_tick edge yields one expected snapshot.
  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      if (frame_tick) begin
        #1;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL queue_empty: got tick with no expectation at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("state", int'(game_state), e.st);
          check("ball_x", int'(ball_x), e.bx);
          check("ball_y", int'(ball_y), e.by);
          check("pad_l_y", int'(pad_l_y), e.pl);
          check("pad_r_y", int'(pad_r_y), e.pr);
          check("score_l", int'(score_l), e.sl);
          check("score_r", int'(score_r), e.sr);
        end
      end
    end
  end

  initial begin : stimulus
    int frames;
    bit done;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Game 1: start with select coincident with a tick, hold up through the serve.
    press_select_on_tick();
    for (int i = 0; i < 30; i++) do_frame(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) do_frame(1'b1, 1'b1);
    frames = 0;
    done = 1'b0;
    while (!done && frames < 8000) begin
      resolve();
      if (m_st == int'(ST_OVER)) done = 1'b1;
      else begin
        auto_frame();
        frames++;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL game_over_timeout: got state %0d expected %0d", int'(game_state), int'(ST_OVER));
    end

    // Over -> idle: scores held, ball recentred; then a new game clears scores.
    press_select();
    for (int i = 0; i < 3; i++) do_frame(1'b0, 1'b1);
    press_select();
    frames = 0;
    while (m_st != int'(ST_PLAY) && frames < 200) begin
      auto_frame();
      frames++;
    end
    for (int i = 0; i < 40; i++) auto_frame();

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("async");
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    press_select();
    for (int i = 0; i < 80; i++) auto_frame();

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
